// File: rtl/memory_access_unit.sv
// Load/store unit: computes the effective address, runs one request/ack handshake
// with data memory, and aligns/extends load data or lane-replicates store data.

package memory_access_unit_pkg;

  localparam int unsigned IMM_W = 12;

  // One-hot access type plus the raw I/S-type immediate
  typedef struct packed {
    logic             lb;
    logic             lh;
    logic             lw;
    logic             lbu;
    logic             lhu;
    logic             sb;
    logic             sh;
    logic             sw;
    logic [IMM_W-1:0] imm;
  } control_info;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

endpackage

module memory_access_unit
  import memory_access_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_ENABLED,
  input  control_info CTR_INFO,
  input  logic [31:0] RS1_VAL,
  input  logic [31:0] RS2_VAL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic [31:0] LOAD_RESULT,
  output logic        MEM_DONE,
  output logic        MEM_BUSY,
  output logic        ERR_MISALIGN,
  output logic        ERR_TIMEOUT
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          lo_q, lo_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_mis_q, err_mis_d;
  logic                err_to_q, err_to_d;

  logic                is_load;
  logic                is_store;
  size_e               acc_size;
  logic                acc_uns;
  logic [DATA_W-1:0]   eff_addr;
  logic                misalign;
  logic [BE_W-1:0]     st_be;
  logic [DATA_W-1:0]   st_wdata;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_data;
  logic                cnt_expired;

  // Decode the access type and compute the effective address
  always_comb begin
    is_load  = CTR_INFO.lb | CTR_INFO.lh | CTR_INFO.lw | CTR_INFO.lbu | CTR_INFO.lhu;
    is_store = ~is_load & (CTR_INFO.sb | CTR_INFO.sh | CTR_INFO.sw);
    acc_uns  = CTR_INFO.lbu | CTR_INFO.lhu;
    if (CTR_INFO.lb | CTR_INFO.lbu | CTR_INFO.sb) begin
      acc_size = SZ_BYTE;
    end else if (CTR_INFO.lh | CTR_INFO.lhu | CTR_INFO.sh) begin
      acc_size = SZ_HALF;
    end else begin
      acc_size = SZ_WORD;
    end
    eff_addr = RS1_VAL + {{(DATA_W-IMM_W){CTR_INFO.imm[IMM_W-1]}}, CTR_INFO.imm};
    misalign = ((acc_size == SZ_HALF) && eff_addr[0]) ||
               ((acc_size == SZ_WORD) && (eff_addr[1:0] != 2'b00));
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    st_be    = {BE_W{1'b1}};
    st_wdata = '0;
    if (is_store) begin
      unique case (acc_size)
        SZ_BYTE: begin
          st_be    = BE_W'(4'b0001 << eff_addr[1:0]);
          st_wdata = {4{RS2_VAL[7:0]}};
        end
        SZ_HALF: begin
          st_be    = BE_W'(4'b0011 << eff_addr[1:0]);
          st_wdata = {2{RS2_VAL[15:0]}};
        end
        default: begin
          st_be    = {BE_W{1'b1}};
          st_wdata = RS2_VAL;
        end
      endcase
    end
  end

  // Select the addressed lane from read data and extend it
  always_comb begin
    unique case (lo_q)
      2'd0:    ld_byte = DMEM_RDATA[7:0];
      2'd1:    ld_byte = DMEM_RDATA[15:8];
      2'd2:    ld_byte = DMEM_RDATA[23:16];
      default: ld_byte = DMEM_RDATA[31:24];
    endcase
    ld_half = lo_q[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    unique case (size_q)
      SZ_BYTE: ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = DMEM_RDATA;
    endcase
  end

  assign cnt_expired = (32'(cnt_q) + 32'd1) >= 32'(ACK_TIMEOUT);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    lo_d      = lo_q;
    size_d    = size_q;
    uns_d     = uns_q;
    result_d  = result_q;
    err_mis_d = err_mis_q;
    err_to_d  = err_to_q;

    unique case (state_q)
      IDLE: begin
        if (MEM_ENABLED) begin
          err_mis_d = 1'b0;
          err_to_d  = 1'b0;
          if (!is_load && !is_store) begin
            state_d = DONE;
          end else if (misalign) begin
            state_d   = DONE;
            err_mis_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {eff_addr[DATA_W-1:2], 2'b00};
            be_d    = st_be;
            wdata_d = st_wdata;
            lo_d    = eff_addr[1:0];
            size_d  = acc_size;
            uns_d   = acc_uns;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        if (DMEM_ACK) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            result_d = ld_data;
          end
        end else if (cnt_expired) begin
          state_d  = DONE;
          req_d    = 1'b0;
          we_d     = 1'b0;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  assign DMEM_REQ     = req_q;
  assign DMEM_WE      = we_q;
  assign DMEM_ADDR    = addr_q;
  assign DMEM_BE      = be_q;
  assign DMEM_WDATA   = wdata_q;
  assign LOAD_RESULT  = result_q;
  assign MEM_DONE     = done_q;
  assign MEM_BUSY     = busy_q;
  assign ERR_MISALIGN = err_mis_q;
  assign ERR_TIMEOUT  = err_to_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed vector table, reset sequences, then
// random transactions checked against an arithmetic reference model.

module tb_memory_access_unit;
  import memory_access_unit_pkg::*;

  localparam int unsigned TO     = 4;
  localparam logic [1:0]  K_REQ  = 2'd0;
  localparam logic [1:0]  K_MIS  = 2'd1;
  localparam logic [1:0]  K_NONE = 2'd2;

  // op: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw
  typedef struct {
    int          op;
    logic [31:0] rs1;
    logic [11:0] imm;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          delay;
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        to;
    logic [31:0] result;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_ENABLED;
  control_info CTR_INFO;
  logic [31:0] RS1_VAL;
  logic [31:0] RS2_VAL;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_WDATA;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic [31:0] LOAD_RESULT;
  logic        MEM_DONE;
  logic        MEM_BUSY;
  logic        ERR_MISALIGN;
  logic        ERR_TIMEOUT;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_result = 32'h0;
  logic        exp_mis = 1'b0;
  logic        exp_to = 1'b0;
  vec_t        tbl[14];

  memory_access_unit #(.ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .MEM_ENABLED(MEM_ENABLED), .CTR_INFO(CTR_INFO),
    .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK), .LOAD_RESULT(LOAD_RESULT),
    .MEM_DONE(MEM_DONE), .MEM_BUSY(MEM_BUSY), .ERR_MISALIGN(ERR_MISALIGN),
    .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic control_info ctr_of(input int op, input logic [11:0] imm);
    control_info c;
    c = '0;
    case (op)
      1: c.lb  = 1'b1;
      2: c.lh  = 1'b1;
      3: c.lw  = 1'b1;
      4: c.lbu = 1'b1;
      5: c.lhu = 1'b1;
      6: c.sb  = 1'b1;
      7: c.sh  = 1'b1;
      8: c.sw  = 1'b1;
      default: ;
    endcase
    c.imm = imm;
    return c;
  endfunction

  function automatic vec_t mk(input int op, input logic [31:0] rs1, input logic [11:0] imm,
                              input logic [31:0] rs2, input logic [31:0] rdata, input int delay,
                              input logic [1:0] kind, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic we, input logic to,
                              input logic [31:0] result);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2; v.rdata = rdata; v.delay = delay;
    v.kind = kind; v.addr = addr; v.be = be; v.wdata = wdata; v.we = we; v.to = to;
    v.result = result;
    return v;
  endfunction

  // Reference model: access size in bytes, offset within the word, plain arithmetic
  function automatic vec_t model_txn(input int op, input logic [31:0] rs1, input logic [11:0] imm,
                                     input logic [31:0] rs2, input logic [31:0] rdata,
                                     input int delay, input logic [31:0] prev);
    vec_t        v;
    int          size;
    bit          st;
    bit          sgn;
    logic [31:0] ea;
    int          off;
    longint      span;
    longint      val;
    v = mk(op, rs1, imm, rs2, rdata, delay, K_NONE, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, prev);
    st = (op >= 6);
    sgn = (op == 1) || (op == 2);
    case (op)
      1, 4, 6: size = 1;
      2, 5, 7: size = 2;
      3, 8:    size = 4;
      default: size = 0;
    endcase
    ea = rs1 + 32'($signed(imm));
    off = int'(ea % 32'd4);
    if (size == 0) begin
      v.kind = K_NONE;
    end else if ((off % size) != 0) begin
      v.kind = K_MIS;
    end else begin
      v.kind = K_REQ;
      v.addr = ea - 32'(off);
      v.we = st;
      v.to = (delay >= int'(TO));
      if (st) begin
        v.be = 4'(((1 << size) - 1) << off);
        if (size == 1)      v.wdata = {24'h0, rs2[7:0]} * 32'h01010101;
        else if (size == 2) v.wdata = {16'h0, rs2[15:0]} * 32'h00010001;
        else                v.wdata = rs2;
      end else begin
        v.be = 4'hF;
        if (!v.to) begin
          span = 64'sd1 << (8 * size);
          val = (longint'(rdata) >> (8 * off)) % span;
          if (sgn && (val >= span / 2)) val = val - span;
          v.result = 32'(val);
        end
      end
    end
    return v;
  endfunction

  // Junk on inputs the DUT must ignore while busy
  task automatic junk();
    MEM_ENABLED = 1'($urandom_range(0, 1));
    CTR_INFO    = ctr_of(int'($urandom_range(0, 8)), 12'($urandom));
    RS1_VAL     = $urandom;
    RS2_VAL     = $urandom;
  endtask

  // Starts at a negedge with the DUT idle and ends at a negedge with it idle again
  task automatic run_txn(input vec_t v);
    int c;
    bit acked;
    MEM_ENABLED = 1'b1;
    CTR_INFO    = ctr_of(v.op, v.imm);
    RS1_VAL     = v.rs1;
    RS2_VAL     = v.rs2;
    DMEM_ACK    = 1'($urandom_range(0, 1));
    DMEM_RDATA  = $urandom;
    @(negedge CLK);
    junk();
    if (v.kind != K_REQ) begin
      exp_mis = (v.kind == K_MIS);
      exp_to  = 1'b0;
      chk("imm_done", 32'(MEM_DONE), 32'd1);
      chk("imm_req", 32'(DMEM_REQ), 32'd0);
      chk("imm_busy", 32'(MEM_BUSY), 32'd1);
      chk("imm_err_mis", 32'(ERR_MISALIGN), 32'(exp_mis));
      chk("imm_err_to", 32'(ERR_TIMEOUT), 32'd0);
      chk("imm_result", LOAD_RESULT, v.result);
    end else begin
      exp_mis = 1'b0;
      exp_to  = v.to;
      c = 0;
      acked = 1'b0;
      while (c < int'(TO) && !acked) begin
        chk("req_req", 32'(DMEM_REQ), 32'd1);
        chk("req_done", 32'(MEM_DONE), 32'd0);
        chk("req_busy", 32'(MEM_BUSY), 32'd1);
        chk("req_we", 32'(DMEM_WE), 32'(v.we));
        chk("req_addr", DMEM_ADDR, v.addr);
        chk("req_be", 32'(DMEM_BE), 32'(v.be));
        if (v.we) chk("req_wdata", DMEM_WDATA, v.wdata);
        chk("req_err", {30'h0, ERR_MISALIGN, ERR_TIMEOUT}, 32'h0);
        chk("req_result_held", LOAD_RESULT, exp_result);
        if (c == v.delay) begin
          DMEM_ACK   = 1'b1;
          DMEM_RDATA = v.rdata;
          acked      = 1'b1;
        end else begin
          DMEM_ACK   = 1'b0;
          DMEM_RDATA = $urandom;
        end
        junk();
        @(negedge CLK);
        c++;
      end
      chk("done_pulse", 32'(MEM_DONE), 32'd1);
      chk("done_req", 32'(DMEM_REQ), 32'd0);
      chk("done_busy", 32'(MEM_BUSY), 32'd1);
      chk("done_err_to", 32'(ERR_TIMEOUT), 32'(v.to));
      chk("done_err_mis", 32'(ERR_MISALIGN), 32'd0);
      chk("done_result", LOAD_RESULT, v.result);
    end
    DMEM_ACK   = 1'($urandom_range(0, 1));
    DMEM_RDATA = $urandom;
    junk();
    @(negedge CLK);
    chk("idle_done", 32'(MEM_DONE), 32'd0);
    chk("idle_busy", 32'(MEM_BUSY), 32'd0);
    chk("idle_req", 32'(DMEM_REQ), 32'd0);
    chk("idle_flags", {30'h0, ERR_MISALIGN, ERR_TIMEOUT}, {30'h0, exp_mis, exp_to});
    chk("idle_result", LOAD_RESULT, v.result);
    exp_result  = v.result;
    MEM_ENABLED = 1'b0;
    DMEM_ACK    = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {26'h0, DMEM_REQ, DMEM_WE, MEM_DONE, MEM_BUSY, ERR_MISALIGN, ERR_TIMEOUT}, 32'h0);
    chk({nm, "_addr"}, DMEM_ADDR, 32'h0);
    chk({nm, "_be"}, 32'(DMEM_BE), 32'h0);
    chk({nm, "_wdata"}, DMEM_WDATA, 32'h0);
    chk({nm, "_result"}, LOAD_RESULT, 32'h0);
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; MEM_ENABLED = 1'b0; CTR_INFO = '0; RS1_VAL = '0; RS2_VAL = '0;
    DMEM_ACK = 1'b0; DMEM_RDATA = '0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset_state");
    RST = 1'b0;
    @(negedge CLK);

    //            op rs1           imm      rs2           rdata         dly kind    addr          be       wdata         we    to    result
    tbl[0]  = mk(1, 32'h00000100, 12'h003, 32'h0,        32'h80000000, 0, K_REQ,  32'h00000100, 4'hF,    32'h0,        1'b0, 1'b0, 32'hFFFFFF80);
    tbl[1]  = mk(7, 32'h00000200, 12'h002, 32'h1234ABCD, 32'h0,        3, K_REQ,  32'h00000200, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 32'hFFFFFF80);
    tbl[2]  = mk(3, 32'h00000101, 12'h000, 32'h0,        32'h0,        0, K_MIS,  32'h0,        4'h0,    32'h0,        1'b0, 1'b0, 32'hFFFFFF80);
    tbl[3]  = mk(8, 32'h00000300, 12'h000, 32'hDEADBEEF, 32'h0,        9, K_REQ,  32'h00000300, 4'hF,    32'hDEADBEEF, 1'b1, 1'b1, 32'hFFFFFF80);
    // Effective address 2 selects the upper halfword of the read word
    tbl[4]  = mk(5, 32'hFFFFFFFE, 12'h004, 32'h0,        32'h0000F00D, 0, K_REQ,  32'h00000000, 4'hF,    32'h0,        1'b0, 1'b0, 32'h00000000);
    tbl[5]  = mk(5, 32'hFFFFFFFE, 12'h004, 32'h0,        32'hF00D0000, 0, K_REQ,  32'h00000000, 4'hF,    32'h0,        1'b0, 1'b0, 32'h0000F00D);
    tbl[6]  = mk(0, 32'h00000100, 12'h001, 32'h0,        32'h0,        0, K_NONE, 32'h0,        4'h0,    32'h0,        1'b0, 1'b0, 32'h0000F00D);
    tbl[7]  = mk(4, 32'h00000040, 12'hFFF, 32'h0,        32'h9A000000, 2, K_REQ,  32'h0000003C, 4'hF,    32'h0,        1'b0, 1'b0, 32'h0000009A);
    tbl[8]  = mk(2, 32'h00000010, 12'h002, 32'h0,        32'h80011234, 0, K_REQ,  32'h00000010, 4'hF,    32'h0,        1'b0, 1'b0, 32'hFFFF8001);
    tbl[9]  = mk(6, 32'h00000020, 12'h001, 32'h0000005A, 32'h0,        1, K_REQ,  32'h00000020, 4'b0010, 32'h5A5A5A5A, 1'b1, 1'b0, 32'hFFFF8001);
    tbl[10] = mk(2, 32'h00000011, 12'h000, 32'h0,        32'h0,        0, K_MIS,  32'h0,        4'h0,    32'h0,        1'b0, 1'b0, 32'hFFFF8001);
    tbl[11] = mk(3, 32'h00001000, 12'h7FC, 32'h0,        32'hCAFEF00D, 1, K_REQ,  32'h000017FC, 4'hF,    32'h0,        1'b0, 1'b0, 32'hCAFEF00D);
    tbl[12] = mk(3, 32'h00000080, 12'h000, 32'h0,        32'h11111111, 4, K_REQ,  32'h00000080, 4'hF,    32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
    tbl[13] = mk(7, 32'h00000300, 12'h000, 32'h0000BEEF, 32'h0,        0, K_REQ,  32'h00000300, 4'b0011, 32'hBEEFBEEF, 1'b1, 1'b0, 32'hCAFEF00D);

    for (int i = 0; i < 14; i++) run_txn(tbl[i]);

    // Reset in the second REQ cycle with an ACK in the same cycle
    MEM_ENABLED = 1'b1; CTR_INFO = ctr_of(3, 12'h0); RS1_VAL = 32'h400; DMEM_ACK = 1'b0;
    @(negedge CLK);
    MEM_ENABLED = 1'b0;
    @(negedge CLK);
    chk("rst_req_before", 32'(DMEM_REQ), 32'd1);
    RST = 1'b1; DMEM_ACK = 1'b1; DMEM_RDATA = 32'h12345678;
    @(negedge CLK);
    chk_all_zero("rst_in_req");
    RST = 1'b0; DMEM_ACK = 1'b0;
    @(negedge CLK);
    chk("rst_no_done", 32'(MEM_DONE), 32'd0);
    chk("rst_result", LOAD_RESULT, 32'h0);
    exp_result = 32'h0; exp_mis = 1'b0; exp_to = 1'b0;

    // Start pulse coincident with reset is dropped
    RST = 1'b1; MEM_ENABLED = 1'b1; CTR_INFO = ctr_of(3, 12'h0); RS1_VAL = 32'h500;
    @(negedge CLK);
    RST = 1'b0; MEM_ENABLED = 1'b0;
    @(negedge CLK);
    chk("rst_start_busy", 32'(MEM_BUSY), 32'd0);
    chk("rst_start_req", 32'(DMEM_REQ), 32'd0);
    chk("rst_start_done", 32'(MEM_DONE), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] rs1;
      rs1 = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFFFFFC) : $urandom;
      v = model_txn(int'($urandom_range(0, 8)), rs1, 12'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 5)), exp_result);
      run_txn(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
